icache: RTL and testbench
=========================

# icache

Direct-mapped, one-word-per-line instruction cache between the program counter and instruction memory. It takes the word-addressed `pc` from the datapath and returns `instr` in the same cycle on a hit. On a miss it raises `stall` so the core holds `pc`, fetches the word over a req/gnt/rvalid memory port, fills the line, and then hits. It also keeps hit/miss performance counters.

## Interface
- `IDX_W`, default 4: index width; line count = 2^IDX_W.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `pc`  in  32  word address of the current instruction; `pc + 1` is the next word.
- `inv`  in  1  one-cycle pulse; invalidates all lines.
- `instr`  out  32  cached word on hit; `32'h0` (NOP) otherwise.
- `hit`  out  1  combinational: line valid and tag matches, and `rst` is low.
- `stall`  out  1  equals `!hit`; the core gates its `pc` update with this.
- `imem_req`  out  1  fetch request, Moore output of the FSM.
- `imem_addr`  out  32  word address of the request; stable while `imem_req` is high.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  `imem_rdata` is valid; arrives at least 1 cycle after `gnt`.
- `imem_rdata`  in  32  returned instruction word.
- `hit_cnt`  out  32  count of cycles with `hit == 1`.
- `miss_cnt`  out  32  count of misses issued.

## Operation
- Address split: `idx = pc[IDX_W-1:0]`, `tag = pc[31:IDX_W]`.
- Per-line storage: `valid` bit, tag of width 32-IDX_W, 32-bit data.
- Hit path is purely combinational: `hit = valid[idx] && tag_q[idx]==tag && !rst`.
- FSM states:
  - IDLE: if `!hit && !inv`, latch `miss_addr <= pc`, increment `miss_cnt`, go to REQ.
  - REQ: `imem_req = 1`, `imem_addr = miss_addr`. Stay until `imem_gnt`, then go to WAIT.
  - WAIT: on `imem_rvalid`, write the line at `miss_addr` (valid=1, tag, data) unless `drop` is set, clear `drop`, go to IDLE.
- Only one request is outstanding at a time. `imem_rvalid` is ignored outside WAIT.
- If `pc` changes during a miss (it should not, because of `stall`), the fill still completes to `miss_addr`. IDLE then re-evaluates the new `pc`.
- `inv` clears every valid bit in one cycle.
  - `inv` in REQ or WAIT sets `drop`; the returning word is discarded and not written.
  - `inv` and `imem_rvalid` in the same cycle: `inv` wins, no write, go to IDLE.
  - `inv` in IDLE suppresses miss detection that cycle.
- Counters wrap modulo 2^32. `hit_cnt` increments on every cycle with `hit`.

## Timing
- Reset values: state IDLE, all valid=0, `drop`=0, `imem_req`=0, `imem_addr`=0, `hit_cnt`=0, `miss_cnt`=0.
- During and after reset: `hit`=0, `stall`=1, `instr`=0.
- Hit latency: 0 cycles, combinational from `pc`.
- Minimum miss penalty is 3 stall cycles:
  - C0: miss seen in IDLE.
  - C1: `imem_req` high, `gnt` arrives.
  - C2: WAIT, `rvalid` arrives, fill written at the edge.
  - C3: hit.
- Each cycle of `gnt` delay or extra `rvalid` latency adds one stall cycle.
- Reset mid-miss aborts immediately: `imem_req` is low the next cycle, and a late `rvalid` is ignored.
- A tag/data write and a same-line lookup in the same cycle return the old contents; the new word is visible the next cycle.

## Structure
- Package `icache_pkg`:
  - state enum `icache_state_t` {IDLE, REQ, WAIT};
  - constant `NOP_INSTR = 32'h0`;
  - default `IDX_W`.
- One sub-module, `icache_array`: valid/tag/data storage with synchronous write, asynchronous read, and a synchronous clear-all driven by `rst | inv`.
- The FSM, counters and `drop` flag live in `icache`.

## Test plan
- Cold start: reset, then `pc=0`, `gnt` immediate, `rvalid` 1 cycle later with `rdata=32'h20080005` → `stall` high for 3 cycles, then `instr=32'h20080005`, `hit=1`, `miss_cnt=1`.
- Sequential fetch of `pc` 0..3, then jump back to `pc=0` → the four misses fill lines; revisiting `pc=0` hits with 0 stall cycles, and `hit_cnt` increments each hit cycle.
- Conflict with `IDX_W=4`: `pc=0x00` fill, then `pc=0x10` → miss on the same index and replacement; returning to `pc=0x00` misses again, giving `miss_cnt=3`.
- Back-pressure: `gnt` delayed 4 cycles and `rvalid` 3 cycles after `gnt` → `imem_req` and `imem_addr` stay stable while waiting, and `stall` lasts 3+4+2=9 cycles.
- `inv` pulsed in WAIT, same cycle as `rvalid` → line not written, FSM returns to IDLE, the next cycle misses again with a new request for the same address.
- `rst` asserted in WAIT, then a stray `rvalid` → `imem_req=0`, no line written, counters read 0, `stall=1` until the next fill.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT} icache_state_t;

   localparam logic [31:0] NOP_INSTR     = 32'h0;
   localparam int          IDX_W_DEFAULT = 4;
endpackage

// File: rtl/icache_array.sv
// Valid/tag/data line storage: synchronous write and clear-all, asynchronous read.
module icache_array
   import icache_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEFAULT
) (
   input  logic              clk,
   input  logic              i_clr,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_widx,
   input  logic [31-IDX_W:0] i_wtag,
   input  logic [31:0]       i_wdata,
   input  logic [IDX_W-1:0]  i_ridx,
   output logic              o_valid,
   output logic [31-IDX_W:0] o_tag,
   output logic [31:0]       o_data
);
   localparam int LINES = 1 << IDX_W;

   logic [LINES-1:0]  r_valid;
   logic [31-IDX_W:0] r_tag  [LINES];
   logic [31:0]       r_data [LINES];

   // Clear beats a same-cycle write, so an invalidate always leaves every line empty.
   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_valid <= '0;
      end else if (i_we) begin
         r_valid[i_widx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_tag[i_widx]  <= i_wtag;
         r_data[i_widx] <= i_wdata;
      end
   end

   assign o_valid = r_valid[i_ridx];
   assign o_tag   = r_tag[i_ridx];
   assign o_data  = r_data[i_ridx];
endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a req/gnt/rvalid refill port.
module icache
   import icache_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        inv,
   output logic [31:0] instr,
   output logic        hit,
   output logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);
   icache_state_t r_state, w_state_next;
   logic          r_drop, w_drop_next;
   logic [31:0]   r_miss_addr, w_miss_addr_next;
   logic [31:0]   r_hit_cnt, r_miss_cnt;
   logic          w_miss_inc, w_fill;
   logic          w_valid, w_hit;
   logic [31-IDX_W:0] w_tag;
   logic [31:0]       w_data;

   icache_array #(.IDX_W(IDX_W)) u_array (
      .clk     (clk),
      .i_clr   (rst | inv),
      .i_we    (w_fill & ~rst),
      .i_widx  (r_miss_addr[IDX_W-1:0]),
      .i_wtag  (r_miss_addr[31:IDX_W]),
      .i_wdata (imem_rdata),
      .i_ridx  (pc[IDX_W-1:0]),
      .o_valid (w_valid),
      .o_tag   (w_tag),
      .o_data  (w_data)
   );

   assign w_hit = w_valid && (w_tag == pc[31:IDX_W]) && !rst;

   always_comb begin
      w_state_next     = r_state;
      w_drop_next      = r_drop;
      w_miss_addr_next = r_miss_addr;
      w_miss_inc       = 1'b0;
      w_fill           = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_hit && !inv) begin
               w_miss_addr_next = pc;
               w_miss_inc       = 1'b1;
               w_state_next     = REQ;
            end
         end
         REQ: begin
            if (inv) w_drop_next = 1'b1;
            if (imem_gnt) w_state_next = WAIT;
         end
         WAIT: begin
            // A word requested before an invalidate may be stale, so it is dropped.
            if (imem_rvalid) begin
               w_fill       = !r_drop && !inv;
               w_drop_next  = 1'b0;
               w_state_next = IDLE;
            end else if (inv) begin
               w_drop_next = 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_drop      <= 1'b0;
         r_miss_addr <= '0;
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
      end else begin
         r_state     <= w_state_next;
         r_drop      <= w_drop_next;
         r_miss_addr <= w_miss_addr_next;
         if (w_hit)      r_hit_cnt  <= r_hit_cnt + 32'd1;
         if (w_miss_inc) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign hit       = w_hit;
   assign stall     = !w_hit;
   assign instr     = w_hit ? w_data : NOP_INSTR;
   assign imem_req  = (r_state == REQ);
   assign imem_addr = r_miss_addr;
   assign hit_cnt   = r_hit_cnt;
   assign miss_cnt  = r_miss_cnt;
endmodule

// File: tb/tb_icache.sv
// Directed-vector bench for icache: refill timing, conflicts, back-pressure, invalidate and reset.
module tb_icache;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = '0;
   logic        inv = 1'b0;
   logic [31:0] instr;
   logic        hit, stall, imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] hit_cnt, miss_cnt;

   int checks = 0;
   int errors = 0;

   icache #(.IDX_W(4)) dut (
      .clk(clk), .rst(rst), .pc(pc), .inv(inv), .instr(instr), .hit(hit), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   // Stimulus only: present pc and act as memory until the cache stops stalling.
   // Called and returns just after a falling edge; the cycle it returns in is the hit cycle.
   task automatic fetch(input logic [31:0] a, input int gd, input int rd, input logic [31:0] d,
                        output int stalls, output bit addr_ok);
      int wg, rc;
      bit granted;
      wg = 0; rc = 0; granted = 0; stalls = 0; addr_ok = 1;
      pc = a; imem_gnt = 0; imem_rvalid = 0;
      #1;
      while (stall && stalls < 200) begin
         stalls++;
         imem_gnt = 0; imem_rvalid = 0;
         if (imem_req) begin
            if (imem_addr !== a) addr_ok = 0;
            if (wg == gd) begin imem_gnt = 1; granted = 1; rc = 0; end
            else wg++;
         end else if (granted) begin
            rc++;
            if (rc == rd) begin imem_rvalid = 1; imem_rdata = d; granted = 0; end
         end
         @(negedge clk); #1;
      end
      imem_gnt = 0; imem_rvalid = 0;
      $display("fetch pc=%h stalls=%0d instr=%h miss_cnt=%0d", a, stalls, instr, miss_cnt);
   endtask

   task automatic do_reset();
      rst = 1; inv = 0; imem_gnt = 0; imem_rvalid = 0; pc = 0;
      repeat (2) @(negedge clk);
      #1; rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; pc = 0; inv = 0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (hit !== 1'b0)       begin errors++; $display("FAIL rst_hit got %0b exp 0", hit); end
      checks++; if (stall !== 1'b1)     begin errors++; $display("FAIL rst_stall got %0b exp 1", stall); end
      checks++; if (instr !== 32'h0)    begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
      checks++; if (imem_req !== 1'b0)  begin errors++; $display("FAIL rst_req got %0b exp 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
      checks++; if (hit_cnt !== 32'h0)  begin errors++; $display("FAIL rst_hit_cnt got %0d exp 0", hit_cnt); end
      checks++; if (miss_cnt !== 32'h0) begin errors++; $display("FAIL rst_miss_cnt got %0d exp 0", miss_cnt); end
      rst = 0;
   endtask

   task automatic test_cold_start();
      int s; bit ok;
      fetch(32'h0, 0, 1, 32'h20080005, s, ok);
      checks++; if (s != 3)                 begin errors++; $display("FAIL cold_stalls got %0d exp 3", s); end
      checks++; if (instr !== 32'h20080005) begin errors++; $display("FAIL cold_instr got %h exp 20080005", instr); end
      checks++; if (hit !== 1'b1)           begin errors++; $display("FAIL cold_hit got %0b exp 1", hit); end
      checks++; if (miss_cnt !== 32'd1)     begin errors++; $display("FAIL cold_miss_cnt got %0d exp 1", miss_cnt); end
   endtask

   task automatic test_sequential();
      int s; bit ok;
      for (int i = 1; i < 4; i++) begin
         fetch(32'(i), 0, 1, 32'hA000_0000 + 32'(i), s, ok);
         checks++; if (s != 3) begin errors++; $display("FAIL seq_stalls pc=%0d got %0d exp 3", i, s); end
      end
      pc = 32'h0; #1;
      checks++; if (stall !== 1'b0)         begin errors++; $display("FAIL seq_back_stall got %0b exp 0", stall); end
      checks++; if (instr !== 32'h20080005) begin errors++; $display("FAIL seq_back_instr got %h exp 20080005", instr); end
      checks++; if (hit_cnt !== 32'd0)      begin errors++; $display("FAIL seq_hit_cnt0 got %0d exp 0", hit_cnt); end
      @(negedge clk); #1;
      checks++; if (hit_cnt !== 32'd1)      begin errors++; $display("FAIL seq_hit_cnt1 got %0d exp 1", hit_cnt); end
      pc = 32'h2;
      @(negedge clk); #1;
      checks++; if (hit_cnt !== 32'd2)      begin errors++; $display("FAIL seq_hit_cnt2 got %0d exp 2", hit_cnt); end
      checks++; if (instr !== 32'hA0000002) begin errors++; $display("FAIL seq_instr2 got %h exp a0000002", instr); end
      checks++; if (miss_cnt !== 32'd4)     begin errors++; $display("FAIL seq_miss_cnt got %0d exp 4", miss_cnt); end
   endtask

   task automatic test_conflict();
      int s; bit ok;
      do_reset();
      fetch(32'h00, 0, 1, 32'h1111_0000, s, ok);
      fetch(32'h10, 0, 1, 32'h2222_0010, s, ok);
      checks++; if (s != 3)                 begin errors++; $display("FAIL conf_stalls got %0d exp 3", s); end
      checks++; if (instr !== 32'h22220010) begin errors++; $display("FAIL conf_instr got %h exp 22220010", instr); end
      fetch(32'h00, 0, 1, 32'h1111_0000, s, ok);
      checks++; if (s != 3)                 begin errors++; $display("FAIL conf_back_stalls got %0d exp 3", s); end
      checks++; if (miss_cnt !== 32'd3)     begin errors++; $display("FAIL conf_miss_cnt got %0d exp 3", miss_cnt); end
      checks++; if (instr !== 32'h11110000) begin errors++; $display("FAIL conf_back_instr got %h exp 11110000", instr); end
   endtask

   task automatic test_back_pressure();
      int s; bit ok;
      do_reset();
      fetch(32'h25, 4, 3, 32'hCAFE_0025, s, ok);
      checks++; if (s != 9)                 begin errors++; $display("FAIL bp_stalls got %0d exp 9", s); end
      checks++; if (ok !== 1'b1)            begin errors++; $display("FAIL bp_addr_stable got %0b exp 1", ok); end
      checks++; if (instr !== 32'hCAFE0025) begin errors++; $display("FAIL bp_instr got %h exp cafe0025", instr); end
   endtask

   task automatic test_inv_in_wait();
      do_reset();
      pc = 32'h7; #1;                                   // C0: miss seen
      @(negedge clk); #1; imem_gnt = 1;                 // C1: REQ, grant
      @(negedge clk); #1; imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_0007; inv = 1;
      @(negedge clk); #1; imem_rvalid = 0; inv = 0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL invw_req_idle got %0b exp 0", imem_req); end
      checks++; if (hit !== 1'b0)      begin errors++; $display("FAIL invw_no_write got %0b exp 0", hit); end
      @(negedge clk); #1;
      checks++; if (imem_req !== 1'b1)   begin errors++; $display("FAIL invw_rereq got %0b exp 1", imem_req); end
      checks++; if (imem_addr !== 32'h7) begin errors++; $display("FAIL invw_addr got %h exp 7", imem_addr); end
      checks++; if (miss_cnt !== 32'd2)  begin errors++; $display("FAIL invw_miss_cnt got %0d exp 2", miss_cnt); end
      imem_gnt = 1;
      @(negedge clk); #1; imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hBEEF_0007;
      @(negedge clk); #1; imem_rvalid = 0;
      checks++; if (instr !== 32'hBEEF0007) begin errors++; $display("FAIL invw_refill got %h exp beef0007", instr); end
      // Invalidate while idle: no miss is taken in that cycle.
      pc = 32'hA; inv = 1;
      @(negedge clk); #1; inv = 0;
      checks++; if (imem_req !== 1'b0)  begin errors++; $display("FAIL invi_req got %0b exp 0", imem_req); end
      checks++; if (miss_cnt !== 32'd2) begin errors++; $display("FAIL invi_miss_cnt got %0d exp 2", miss_cnt); end
      pc = 32'h7; #1;
      checks++; if (hit !== 1'b0)       begin errors++; $display("FAIL invi_cleared got %0b exp 0", hit); end
   endtask

   task automatic test_inv_in_req();
      do_reset();
      pc = 32'hB; #1;
      @(negedge clk); #1; inv = 1;                      // REQ, no grant yet
      @(negedge clk); #1; inv = 0; imem_gnt = 1;
      @(negedge clk); #1; imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h5555_000B;
      @(negedge clk); #1; imem_rvalid = 0;
      checks++; if (hit !== 1'b0)      begin errors++; $display("FAIL invr_dropped got %0b exp 0", hit); end
      @(negedge clk); #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL invr_rereq got %0b exp 1", imem_req); end
   endtask

   task automatic test_reset_mid_miss();
      int s; bit ok;
      do_reset();
      fetch(32'h3, 0, 1, 32'h3333_0003, s, ok);
      rst = 1; #1;
      checks++; if (hit !== 1'b0)    begin errors++; $display("FAIL rstm_hit_in_rst got %0b exp 0", hit); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rstm_instr_in_rst got %h exp 0", instr); end
      @(negedge clk); #1; rst = 0; pc = 32'h9;          // C0
      @(negedge clk); #1; imem_gnt = 1;                 // C1
      @(negedge clk); #1; imem_gnt = 0; rst = 1;        // C2: WAIT, reset
      @(negedge clk); #1; rst = 0; imem_rvalid = 1; imem_rdata = 32'h9999_0009;
      checks++; if (imem_req !== 1'b0)  begin errors++; $display("FAIL rstm_req got %0b exp 0", imem_req); end
      checks++; if (miss_cnt !== 32'd0) begin errors++; $display("FAIL rstm_miss_cnt got %0d exp 0", miss_cnt); end
      checks++; if (hit_cnt !== 32'd0)  begin errors++; $display("FAIL rstm_hit_cnt got %0d exp 0", hit_cnt); end
      checks++; if (stall !== 1'b1)     begin errors++; $display("FAIL rstm_stall got %0b exp 1", stall); end
      @(negedge clk); #1; imem_rvalid = 0;
      checks++; if (hit !== 1'b0)       begin errors++; $display("FAIL rstm_stray_written got %0b exp 0", hit); end
      checks++; if (imem_req !== 1'b1)  begin errors++; $display("FAIL rstm_new_req got %0b exp 1", imem_req); end
      imem_gnt = 1;
      @(negedge clk); #1; imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h9999_0009;
      @(negedge clk); #1; imem_rvalid = 0;
      checks++; if (instr !== 32'h99990009) begin errors++; $display("FAIL rstm_fill got %h exp 99990009", instr); end
      pc = 32'h3; #1;
      checks++; if (hit !== 1'b0)       begin errors++; $display("FAIL rstm_old_line got %0b exp 0", hit); end
   endtask

   initial begin
      test_reset();
      test_cold_start();
      test_sequential();
      test_conflict();
      test_back_pressure();
      test_inv_in_wait();
      test_inv_in_req();
      test_reset_mid_miss();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
